decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder.sv | 146 ++++++++++++++
 tb/tb_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// RV32 R-type instruction decoder: one registered cycle from in_valid to decoded fields and ALU flags.
// Optional `illegal` output is built only when DECODER_ILLEGAL_EN is defined.
module decoder #(
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [ILEN-1:0] instruction,
    output logic            out_valid,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            add,
    output logic            sub,
    output logic            sll,
    output logic            slt,
    output logic            sltu,
    output logic            xor_op,
    output logic            srl,
    output logic            sra,
    output logic            or_op,
    output logic            and_op
`ifdef DECODER_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    typedef struct packed {
        logic add;
        logic sub;
        logic sll;
        logic slt;
        logic sltu;
        logic xor_op;
        logic srl;
        logic sra;
        logic or_op;
        logic and_op;
    } alu_flags_t;

    if (ILEN != 32) begin : g_ilen_check
        $error("decoder: only ILEN=32 is supported");
    end

    logic       is_rtype;
    alu_flags_t flags_d, flags_q;
    logic       out_valid_q;
    logic [4:0] rs1_q, rs2_q, rd_q;
    logic [6:0] opcode_q, funct7_q;
    logic [2:0] funct3_q;

    assign is_rtype = (instruction[6:0] == OP_RTYPE);

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        flags_d = '0;
        if (is_rtype) begin
            case (instruction[31:25])
                7'b0000000: begin
                    case (instruction[14:12])
                        3'b000:  flags_d.add    = 1'b1;
                        3'b001:  flags_d.sll    = 1'b1;
                        3'b010:  flags_d.slt    = 1'b1;
                        3'b011:  flags_d.sltu   = 1'b1;
                        3'b100:  flags_d.xor_op = 1'b1;
                        3'b101:  flags_d.srl    = 1'b1;
                        3'b110:  flags_d.or_op  = 1'b1;
                        default: flags_d.and_op = 1'b1;
                    endcase
                end
                7'b0100000: begin
                    if (instruction[14:12] == 3'b000) flags_d.sub = 1'b1;
                    if (instruction[14:12] == 3'b101) flags_d.sra = 1'b1;
                end
                default: flags_d = '0;
            endcase
        end
    end

    // Fields and flags only load on a valid word and otherwise hold; out_valid tracks in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            flags_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid_q <= in_valid;
            if (in_valid) begin
                rs1_q    <= instruction[19:15];
                rs2_q    <= instruction[24:20];
                rd_q     <= instruction[11:7];
                opcode_q <= instruction[6:0];
                funct3_q <= instruction[14:12];
                funct7_q <= instruction[31:25];
                flags_q  <= flags_d;
            end
        end
    end

`ifdef DECODER_ILLEGAL_EN
    logic illegal_d, illegal_q;

    // Only meaningful alongside out_valid, so it is recomputed every cycle rather than held.
    assign illegal_d = in_valid &
                       ((is_rtype && (flags_d == '0)) || (instruction[1:0] != 2'b11));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`endif

    assign out_valid = out_valid_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign opcode    = opcode_q;
    assign funct3    = funct3_q;
    assign funct7    = funct7_q;
    assign add       = flags_q.add;
    assign sub       = flags_q.sub;
    assign sll       = flags_q.sll;
    assign slt       = flags_q.slt;
    assign sltu      = flags_q.sltu;
    assign xor_op    = flags_q.xor_op;
    assign srl       = flags_q.srl;
    assign sra       = flags_q.sra;
    assign or_op     = flags_q.or_op;
    assign and_op    = flags_q.and_op;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: expected outputs are queued as each word is driven and
// compared one cycle later. Define DECODER_ILLEGAL_EN to also check the illegal output.
module tb_decoder;

    typedef struct packed {
        logic       ov;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [9:0] flags;  // add,sub,sll,slt,sltu,xor_op,srl,sra,or_op,and_op
        logic       ill;
    } out_t;

    // {funct7,funct3} encodings in the same order as the flag bits, MSB first
    localparam logic [9:0] ENC [10] = '{
        10'b0000000_000, 10'b0100000_000, 10'b0000000_001, 10'b0000000_010,
        10'b0000000_011, 10'b0000000_100, 10'b0000000_101, 10'b0100000_101,
        10'b0000000_110, 10'b0000000_111
    };

    localparam logic [31:0] ADD_I  = 32'b0000000_00011_00010_000_00101_0110011;
    localparam logic [31:0] SUB_I  = 32'b0100000_00101_00100_000_01010_0110011;
    localparam logic [31:0] ADDI_I = 32'b000000000111_00110_000_01000_0010011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        out_valid, add, sub, sll, slt, sltu, xor_op, srl, sra, or_op, and_op;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        ill_bit;

    int   checks = 0;
    int   errors = 0;
    out_t sb_q[$];
    out_t last_exp = '0;
    out_t got;

    decoder #(.ILEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
        .out_valid(out_valid), .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .add(add), .sub(sub), .sll(sll), .slt(slt),
        .sltu(sltu), .xor_op(xor_op), .srl(srl), .sra(sra), .or_op(or_op), .and_op(and_op)
`ifdef DECODER_ILLEGAL_EN
        , .illegal(ill_bit)
`endif
    );

`ifndef DECODER_ILLEGAL_EN
    assign ill_bit = 1'b0;
`endif

    assign got = {out_valid, rs1, rs2, rd, opcode, funct3, funct7,
                  add, sub, sll, slt, sltu, xor_op, srl, sra, or_op, and_op, ill_bit};

    always #5 clk = ~clk;

    function automatic out_t model(input logic [31:0] w);
        out_t e;
        e = '0;
        e.ov     = 1'b1;
        e.rs1    = w[19:15];
        e.rs2    = w[24:20];
        e.rd     = w[11:7];
        e.opcode = w[6:0];
        e.funct3 = w[14:12];
        e.funct7 = w[31:25];
        if (w[6:0] == 7'b0110011)
            for (int i = 0; i < 10; i++)
                if ({w[31:25], w[14:12]} == ENC[i]) e.flags[9-i] = 1'b1;
`ifdef DECODER_ILLEGAL_EN
        e.ill = ((w[6:0] == 7'b0110011) && (e.flags == '0)) || (w[1:0] != 2'b11);
`endif
        return e;
    endfunction

    // NOTE: bench inputs use blocking assignments, driven on the falling edge away from sampling.
    task automatic drive(input logic v, input logic [31:0] w);
        out_t e;
        @(negedge clk);
        in_valid    = v;
        instruction = w;
        if (v) e = model(w);
        else begin
            e     = last_exp;
            e.ov  = 1'b0;
            e.ill = 1'b0;
        end
        last_exp = e;
        sb_q.push_back(e);
    endtask

    task automatic sample(output out_t g, output out_t e);
        @(posedge clk);
        #1;
        g = got;
        e = sb_q.pop_front();
    endtask

    task automatic flush();
        sb_q.delete();
        last_exp = '0;
    endtask

    task automatic test_reset();
        out_t g, e;
        in_valid    = 1'b1;
        instruction = ADD_I;
        #2;
        checks++;
        if (got !== out_t'('0)) begin errors++; $display("FAIL reset_initial got=%h exp=0", got); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (got !== out_t'('0)) begin errors++; $display("FAIL reset_discard got=%h exp=0", got); end
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        flush();
        drive(1'b1, SUB_I);
        sample(g, e);
        checks++;
        if (g !== e) begin errors++; $display("FAIL first_decode got=%h exp=%h", g, e); end
    endtask

    task automatic test_add_sub();
        out_t g, e, k;
        drive(1'b1, ADD_I);
        sample(g, e);
        k = {1'b1, 5'd2, 5'd3, 5'd5, 7'd51, 3'd0, 7'd0, 10'b1000000000, 1'b0};
        checks++;
        if (g !== k) begin errors++; $display("FAIL add got=%h exp=%h", g, k); end
        drive(1'b1, SUB_I);
        sample(g, e);
        k = {1'b1, 5'd4, 5'd5, 5'd10, 7'd51, 3'd0, 7'd32, 10'b0100000000, 1'b0};
        checks++;
        if (g !== k) begin errors++; $display("FAIL sub got=%h exp=%h", g, k); end
    endtask

    task automatic test_sweep();
        out_t g, e;
        logic [9:0] enc;
        for (int i = 0; i < 10; i++) begin
            enc = ENC[i];
            drive(1'b1, {enc[9:3], 5'(i), 5'(i + 1), enc[2:0], 5'(i + 2), 7'b0110011});
            sample(g, e);
            checks++;
            if (g !== e || g.flags !== (10'b1000000000 >> i))
                begin errors++; $display("FAIL sweep_%0d got=%h exp=%h", i, g, e); end
        end
    endtask

    task automatic test_non_rtype();
        out_t g, e;
        logic [31:0] words [4];
        words = '{ADDI_I, 32'h0000_0000, 32'b0100000_00001_00010_001_00011_0110011,
                  32'b0000001_00001_00010_000_00011_0110011};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[i]);
            sample(g, e);
            checks++;
            if (g !== e || g.flags !== 10'b0)
                begin errors++; $display("FAIL non_rtype_%0d got=%h exp=%h", i, g, e); end
        end
    endtask

    task automatic test_hold();
        out_t g, e;
        drive(1'b1, ADD_I);
        sample(g, e);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, $urandom);
            sample(g, e);
            checks++;
            if (g !== e) begin errors++; $display("FAIL hold_%0d got=%h exp=%h", i, g, e); end
        end
    endtask

    task automatic test_back_to_back();
        out_t g, e;
        logic [31:0] w;
        for (int i = 0; i < 24; i++) begin
            w = $urandom;
            if (i % 3 != 0) w[6:0] = 7'b0110011;
            drive(($urandom % 4) != 0, w);
            sample(g, e);
            checks++;
            if (g !== e) begin errors++; $display("FAIL b2b_%0d got=%h exp=%h", i, g, e); end
        end
    endtask

    task automatic test_async_reset();
        out_t g, e;
        drive(1'b1, ADD_I);
        sample(g, e);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (got !== out_t'('0)) begin errors++; $display("FAIL async_clear got=%h exp=0", got); end
        flush();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, $urandom);
            sample(g, e);
            checks++;
            if (g !== e) begin errors++; $display("FAIL post_reset_%0d got=%h exp=%h", i, g, e); end
        end
        // Reset lands between driving a word and the edge that would capture it.
        drive(1'b1, SUB_I);
        #2;
        rst = 1'b1;
        #1;
        flush();
        checks++;
        if (got !== out_t'('0)) begin errors++; $display("FAIL midstream_clear got=%h exp=0", got); end
        @(posedge clk); #1;
        checks++;
        if (got !== out_t'('0)) begin errors++; $display("FAIL midstream_next got=%h exp=0", got); end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        drive(1'b1, ADDI_I);
        sample(g, e);
        checks++;
        if (g !== e) begin errors++; $display("FAIL resume got=%h exp=%h", g, e); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_sweep();
        test_non_rtype();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
